// File: rtl/ysyx_22040750_pkg.sv
// Shared definitions for the ysyx_22040750 pipeline: writeback source encodings,
// load-strobe layout and a lane-count helper.
package ysyx_22040750_pkg;

  localparam int unsigned XLEN = 64;

  // I_rstrb layout: [7:0] lane mask (already shifted to the offset), [8] sign-extend.
  localparam int unsigned RSTRB_SEXT = 8;

  typedef enum logic [1:0] {
    REGIN_ALU  = 2'b00,
    REGIN_CSR  = 2'b01,
    REGIN_LOAD = 2'b10
  } regin_e;

  function automatic logic [3:0] lane_popcount(input logic [7:0] mask);
    logic [3:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, mask[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ysyx_22040750_load_align.sv
// Combinational load aligner: shifts raw 8-byte-aligned read data down to the access
// offset and zero/sign-extends according to the number of active byte lanes.
module ysyx_22040750_load_align
  import ysyx_22040750_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      offset_i,
  input  logic [8:0]      rstrb_i,
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0] shifted;
  logic            sext;
  logic [3:0]      lanes;

  assign shifted = rdata_i >> {offset_i, 3'b000};
  assign sext    = rstrb_i[RSTRB_SEXT];
  assign lanes   = lane_popcount(rstrb_i[7:0]);

  // Malformed lane masks (popcount not 1/2/4) fall through to the raw shifted word.
  always_comb begin
    result_o = shifted;
    case (lanes)
      4'd1:    result_o = {{(XLEN-8){sext & shifted[7]}},   shifted[7:0]};
      4'd2:    result_o = {{(XLEN-16){sext & shifted[15]}}, shifted[15:0]};
      4'd4:    result_o = {{(XLEN-32){sext & shifted[31]}}, shifted[31:0]};
      default: result_o = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_22040750_mem_wb_reg.sv
// MEM->WB pipeline register: captures retiring instructions, selects the writeback
// value and drives gated regfile/CSR write ports plus a one-cycle commit pulse.
module ysyx_22040750_mem_wb_reg
  import ysyx_22040750_pkg::*;
#(
  parameter int unsigned XLEN = ysyx_22040750_pkg::XLEN,
  parameter int unsigned PC_W = 32
) (
  input  logic            I_sys_clk,
  input  logic            I_rst_n,
  input  logic            I_MEM_WB_valid,
  input  logic            I_MEM_WB_allowout,
  output logic            O_MEM_WB_allowin,
  input  logic [PC_W-1:0] I_pc,
  input  logic [XLEN-1:0] I_alu_out,
  input  logic [XLEN-1:0] I_mem_rdata,
  input  logic [8:0]      I_rstrb,
  input  logic [1:0]      I_regin_sel,
  input  logic            I_reg_wen,
  input  logic [4:0]      I_rd_addr,
  input  logic [XLEN-1:0] I_csr,
  input  logic [11:0]     I_csr_addr,
  input  logic            I_csr_wen,
  input  logic [XLEN-1:0] I_csr_wdata,
  input  logic            I_csr_intr,
  input  logic [XLEN-1:0] I_csr_intr_no,
  input  logic            I_csr_mret,
  input  logic            I_fencei,
  input  logic [31:0]     I_inst_debug,
  input  logic            I_bubble_inst_debug,
  output logic [PC_W-1:0] O_pc,
  output logic            O_reg_wen,
  output logic [4:0]      O_rd_addr,
  output logic [XLEN-1:0] O_rd_data,
  output logic            O_csr_wen,
  output logic [11:0]     O_csr_addr,
  output logic [XLEN-1:0] O_csr_wdata,
  output logic            O_csr_intr,
  output logic [XLEN-1:0] O_csr_intr_no,
  output logic            O_csr_mret,
  output logic            O_fencei,
  output logic            O_fwd_valid,
  output logic            O_commit,
  output logic [31:0]     O_inst_debug,
  output logic            O_bubble_inst_debug
);

  logic            valid_q;
  logic            allowin;
  logic            fire;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] rd_data_d;
  regin_e          regin_sel;

  logic [PC_W-1:0] pc_q;
  logic [XLEN-1:0] rd_data_q;
  logic            reg_wen_q;
  logic [4:0]      rd_addr_q;
  logic            csr_wen_q;
  logic [11:0]     csr_addr_q;
  logic [XLEN-1:0] csr_wdata_q;
  logic            csr_intr_q;
  logic [XLEN-1:0] csr_intr_no_q;
  logic            csr_mret_q;
  logic            fencei_q;
  logic [31:0]     inst_q;
  logic            bubble_q;

  assign allowin = !valid_q || I_MEM_WB_allowout;
  assign fire    = I_MEM_WB_valid && allowin;

  ysyx_22040750_load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .rdata_i  (I_mem_rdata),
    .offset_i (I_alu_out[2:0]),
    .rstrb_i  (I_rstrb),
    .result_o (load_data)
  );

  assign regin_sel = regin_e'(I_regin_sel);

  // Both 1x encodings select the load path.
  always_comb begin
    rd_data_d = load_data;
    case (regin_sel)
      REGIN_ALU: rd_data_d = I_alu_out;
      REGIN_CSR: rd_data_d = I_csr;
      default:   rd_data_d = load_data;
    endcase
  end

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      valid_q       <= 1'b0;
      pc_q          <= '0;
      rd_data_q     <= '0;
      reg_wen_q     <= 1'b0;
      rd_addr_q     <= '0;
      csr_wen_q     <= 1'b0;
      csr_addr_q    <= '0;
      csr_wdata_q   <= '0;
      csr_intr_q    <= 1'b0;
      csr_intr_no_q <= '0;
      csr_mret_q    <= 1'b0;
      fencei_q      <= 1'b0;
      inst_q        <= '0;
      bubble_q      <= 1'b0;
    end else begin
      if (allowin) begin
        valid_q <= I_MEM_WB_valid;
      end
      if (fire) begin
        pc_q          <= I_pc;
        rd_data_q     <= rd_data_d;
        reg_wen_q     <= I_reg_wen;
        rd_addr_q     <= I_rd_addr;
        csr_wen_q     <= I_csr_wen;
        csr_addr_q    <= I_csr_addr;
        csr_wdata_q   <= I_csr_wdata;
        csr_intr_q    <= I_csr_intr;
        csr_intr_no_q <= I_csr_intr_no;
        csr_mret_q    <= I_csr_mret;
        fencei_q      <= I_fencei;
        inst_q        <= I_inst_debug;
        bubble_q      <= I_bubble_inst_debug;
      end
    end
  end

  assign O_MEM_WB_allowin = allowin;

  assign O_pc                = pc_q;
  assign O_rd_addr           = rd_addr_q;
  assign O_rd_data           = rd_data_q;
  assign O_csr_addr          = csr_addr_q;
  assign O_csr_wdata         = csr_wdata_q;
  assign O_csr_intr_no       = csr_intr_no_q;
  assign O_inst_debug        = inst_q;
  assign O_bubble_inst_debug = bubble_q;

  // A trap takes precedence over the instruction's own GPR/CSR writes.
  assign O_reg_wen   = valid_q && reg_wen_q && (rd_addr_q != 5'd0) && !csr_intr_q;
  assign O_csr_wen   = valid_q && csr_wen_q && !csr_intr_q;
  assign O_csr_intr  = valid_q && csr_intr_q;
  assign O_csr_mret  = valid_q && csr_mret_q;
  assign O_fencei    = valid_q && fencei_q;
  assign O_fwd_valid = O_reg_wen;

  // Commit only on the cycle the instruction actually leaves, so stalls never repeat it.
  assign O_commit = valid_q && !bubble_q && I_MEM_WB_allowout;

endmodule

// File: tb/tb_ysyx_22040750_mem_wb_reg.sv
// Self-checking bench for the MEM->WB register: directed vectors, corner sequences
// and randomized traffic against a byte-level behavioural model.
module tb_ysyx_22040750_mem_wb_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid, allowout, allowin;
  logic [31:0] pc_i, pc_o;
  logic [63:0] alu_i, rdata_i, csr_i, cwdata_i, intrno_i;
  logic [8:0]  rstrb_i;
  logic [1:0]  sel_i;
  logic        wen_i, cwen_i, intr_i, mret_i, fencei_i, bubble_i;
  logic [4:0]  rd_i;
  logic [11:0] caddr_i;
  logic [31:0] inst_i;
  logic        reg_wen_o, csr_wen_o, csr_intr_o, csr_mret_o, fencei_o, fwd_o, commit_o, bubble_o;
  logic [4:0]  rd_o;
  logic [63:0] rd_data_o, cwdata_o, intrno_o;
  logic [11:0] caddr_o;
  logic [31:0] inst_o;

  always #5 clk = ~clk;

  ysyx_22040750_mem_wb_reg #(.XLEN(64), .PC_W(32)) dut (
    .I_sys_clk(clk), .I_rst_n(rst_n),
    .I_MEM_WB_valid(in_valid), .I_MEM_WB_allowout(allowout), .O_MEM_WB_allowin(allowin),
    .I_pc(pc_i), .I_alu_out(alu_i), .I_mem_rdata(rdata_i), .I_rstrb(rstrb_i),
    .I_regin_sel(sel_i), .I_reg_wen(wen_i), .I_rd_addr(rd_i),
    .I_csr(csr_i), .I_csr_addr(caddr_i), .I_csr_wen(cwen_i), .I_csr_wdata(cwdata_i),
    .I_csr_intr(intr_i), .I_csr_intr_no(intrno_i), .I_csr_mret(mret_i), .I_fencei(fencei_i),
    .I_inst_debug(inst_i), .I_bubble_inst_debug(bubble_i),
    .O_pc(pc_o), .O_reg_wen(reg_wen_o), .O_rd_addr(rd_o), .O_rd_data(rd_data_o),
    .O_csr_wen(csr_wen_o), .O_csr_addr(caddr_o), .O_csr_wdata(cwdata_o), .O_csr_intr(csr_intr_o),
    .O_csr_intr_no(intrno_o), .O_csr_mret(csr_mret_o), .O_fencei(fencei_o),
    .O_fwd_valid(fwd_o), .O_commit(commit_o), .O_inst_debug(inst_o), .O_bubble_inst_debug(bubble_o)
  );

  typedef struct {
    logic        valid;
    logic        allowout;
    logic [31:0] pc;
    logic [63:0] alu;
    logic [63:0] rdata;
    logic [8:0]  rstrb;
    logic [1:0]  sel;
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] csr;
    logic [11:0] caddr;
    logic        cwen;
    logic [63:0] cwdata;
    logic        intr;
    logic [63:0] intrno;
    logic        mret;
    logic        fencei;
    logic [31:0] inst;
    logic        bubble;
  } in_t;

  typedef struct {
    logic [63:0] rdata;
    logic [63:0] alu;
    logic [8:0]  rstrb;
    logic [1:0]  sel;
    logic [63:0] csr;
    logic [63:0] exp_rd;
  } vec_t;

  int   n_checks = 0;
  int   n_errors = 0;
  int   commits = 0;
  logic m_valid = 1'b0;
  in_t  m_rec;
  in_t  idle;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Byte-level reference: gather N bytes starting at the offset, then extend.
  function automatic logic [63:0] ref_load(input logic [63:0] rdata, input logic [2:0] off,
                                           input logic [8:0] rstrb);
    int n;
    logic [63:0] v;
    n = $countones(rstrb[7:0]);
    v = '0;
    if (n == 1 || n == 2 || n == 4 || n == 8) begin
      for (int i = 0; i < n; i++) begin
        int idx = int'(off) + i;
        if (idx < 8) v[8*i +: 8] = rdata[8*idx +: 8];
      end
      if (rstrb[8] && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
    end else begin
      v = rdata >> (8 * int'(off));
    end
    return v;
  endfunction

  function automatic logic [63:0] ref_rd(input in_t r);
    if (r.sel[1]) return ref_load(r.rdata, r.alu[2:0], r.rstrb);
    if (r.sel[0]) return r.csr;
    return r.alu;
  endfunction

  task automatic drive(input in_t x);
    in_valid = x.valid;  allowout = x.allowout; pc_i = x.pc;       alu_i = x.alu;
    rdata_i  = x.rdata;  rstrb_i  = x.rstrb;    sel_i = x.sel;     wen_i = x.wen;
    rd_i     = x.rd;     csr_i    = x.csr;      caddr_i = x.caddr; cwen_i = x.cwen;
    cwdata_i = x.cwdata; intr_i   = x.intr;     intrno_i = x.intrno;
    mret_i   = x.mret;   fencei_i = x.fencei;   inst_i = x.inst;   bubble_i = x.bubble;
  endtask

  task automatic check_outs();
    chk("pc",        {32'd0, pc_o},       {32'd0, m_rec.pc});
    chk("rd_data",   rd_data_o,           ref_rd(m_rec));
    chk("rd_addr",   {59'd0, rd_o},       {59'd0, m_rec.rd});
    chk("csr_addr",  {52'd0, caddr_o},    {52'd0, m_rec.caddr});
    chk("csr_wdata", cwdata_o,            m_rec.cwdata);
    chk("intr_no",   intrno_o,            m_rec.intrno);
    chk("inst",      {32'd0, inst_o},     {32'd0, m_rec.inst});
    chk("bubble",    {63'd0, bubble_o},   {63'd0, m_rec.bubble});
    chk("reg_wen",   {63'd0, reg_wen_o},  {63'd0, m_valid && m_rec.wen && m_rec.rd != 0 && !m_rec.intr});
    chk("fwd_valid", {63'd0, fwd_o},      {63'd0, m_valid && m_rec.wen && m_rec.rd != 0 && !m_rec.intr});
    chk("csr_wen",   {63'd0, csr_wen_o},  {63'd0, m_valid && m_rec.cwen && !m_rec.intr});
    chk("csr_intr",  {63'd0, csr_intr_o}, {63'd0, m_valid && m_rec.intr});
    chk("csr_mret",  {63'd0, csr_mret_o}, {63'd0, m_valid && m_rec.mret});
    chk("fencei",    {63'd0, fencei_o},   {63'd0, m_valid && m_rec.fencei});
  endtask

  // Entered and left at posedge+1.
  task automatic cycle(input in_t x);
    logic ai;
    drive(x);
    #3;
    ai = !m_valid || x.allowout;
    chk("allowin", {63'd0, allowin},  {63'd0, ai});
    chk("commit",  {63'd0, commit_o}, {63'd0, m_valid && !m_rec.bubble && x.allowout});
    if (commit_o === 1'b1) commits++;
    @(posedge clk);
    if (ai) begin
      if (x.valid) begin
        m_valid = 1'b1;
        m_rec   = x;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    check_outs();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    m_valid = 1'b0;
    m_rec = idle;
    #1;
    chk("rst_commit",  {63'd0, commit_o}, 64'd0);
    chk("rst_allowin", {63'd0, allowin},  64'd1);
    check_outs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_outs();
  endtask

  function automatic in_t rand_in();
    in_t x;
    int n;
    logic [2:0] off;
    logic [15:0] m;
    x.valid = ($urandom_range(0, 9) < 7);
    x.allowout = ($urandom_range(0, 9) < 7);
    x.pc = $urandom;
    off = 3'($urandom_range(0, 7));
    x.alu = {$urandom, $urandom};
    x.alu[2:0] = off;
    x.rdata = {$urandom, $urandom};
    n = 1 << $urandom_range(0, 3);
    m = ((16'd1 << n) - 16'd1) << off;
    x.rstrb = {1'($urandom_range(0, 1)), m[7:0]};
    if ($urandom_range(0, 9) == 0) x.rstrb = 9'($urandom);
    x.sel = 2'($urandom_range(0, 3));
    x.wen = 1'($urandom_range(0, 1));
    x.rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    x.csr = {$urandom, $urandom};
    x.caddr = 12'($urandom);
    x.cwen = 1'($urandom_range(0, 1));
    x.cwdata = {$urandom, $urandom};
    x.intr = ($urandom_range(0, 7) == 0);
    x.intrno = {$urandom, $urandom};
    x.mret = ($urandom_range(0, 7) == 0);
    x.fencei = ($urandom_range(0, 7) == 0);
    x.inst = $urandom;
    x.bubble = ($urandom_range(0, 9) == 0);
    return x;
  endfunction

  vec_t vecs[6];
  in_t  t;

  initial begin
    idle = '{default: '0};
    m_rec = idle;
    drive(idle);
    vecs[0] = '{64'h8877_6655_4433_2211, 64'h1003, 9'h108, 2'b10, 64'd0, 64'h0000_0000_0000_0044};
    vecs[1] = '{64'h8877_6655_4433_2211, 64'h2007, 9'h180, 2'b10, 64'd0, 64'hFFFF_FFFF_FFFF_FF88};
    vecs[2] = '{64'h8877_6655_4433_2211, 64'h3006, 9'h0C0, 2'b10, 64'd0, 64'h0000_0000_0000_8877};
    vecs[3] = '{64'h8877_6655_4433_2211, 64'h4004, 9'h1F0, 2'b11, 64'd0, 64'hFFFF_FFFF_8877_6655};
    vecs[4] = '{64'h0,                   64'h55,   9'h000, 2'b01, 64'h1800, 64'h0000_0000_0000_1800};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hDEAD_BEEF_0123_4567, 9'h1FF, 2'b00, 64'h9, 64'hDEAD_BEEF_0123_4567};

    // Power-on: assert reset between edges, outputs must clear without a clock.
    #1 rst_n = 1'b0;
    #1;
    check_outs();
    chk("por_commit", {63'd0, commit_o}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed load/CSR/ALU vectors.
    for (int i = 0; i < 6; i++) begin
      t = idle;
      t.valid = 1'b1; t.allowout = 1'b1; t.pc = 32'h8000_0000 + 32'(i * 4);
      t.rdata = vecs[i].rdata; t.alu = vecs[i].alu; t.rstrb = vecs[i].rstrb;
      t.sel = vecs[i].sel; t.csr = vecs[i].csr; t.wen = 1'b1; t.rd = 5'd10;
      t.cwen = (vecs[i].sel == 2'b01);
      cycle(t);
      chk($sformatf("vec%0d_rd_data", i), rd_data_o, vecs[i].exp_rd);
      if (vecs[i].sel == 2'b01) chk("vec_csr_wen", {63'd0, csr_wen_o}, 64'd1);
    end

    // Trap suppresses both write enables.
    t = idle;
    t.valid = 1'b1; t.allowout = 1'b1; t.sel = 2'b01; t.csr = 64'h1800;
    t.wen = 1'b1; t.rd = 5'd5; t.cwen = 1'b1; t.intr = 1'b1; t.intrno = 64'h8000_0000_0000_0007;
    cycle(t);
    chk("intr_reg_wen", {63'd0, reg_wen_o},  64'd0);
    chk("intr_csr_wen", {63'd0, csr_wen_o},  64'd0);
    chk("intr_flag",    {63'd0, csr_intr_o}, 64'd1);

    // Stream of four ALU ops, the third targets x0.
    t = idle; t.allowout = 1'b1;
    cycle(t);
    commits = 0;
    for (int i = 0; i < 4; i++) begin
      t = idle;
      t.valid = 1'b1; t.allowout = 1'b1; t.wen = 1'b1; t.alu = 64'(100 + i);
      t.rd = (i == 2) ? 5'd0 : 5'(i + 1); t.pc = 32'(i * 4);
      cycle(t);
      if (i == 2) chk("x0_reg_wen", {63'd0, reg_wen_o}, 64'd0);
    end
    t = idle; t.allowout = 1'b1;
    cycle(t);
    chk("stream_commits", 64'(commits), 64'd4);

    // Stall for three cycles with a second instruction waiting upstream.
    t = idle; t.valid = 1'b1; t.allowout = 1'b1; t.alu = 64'hA; t.wen = 1'b1; t.rd = 5'd3; t.pc = 32'h100;
    cycle(t);
    commits = 0;
    for (int i = 0; i < 3; i++) begin
      t = idle; t.valid = 1'b1; t.allowout = 1'b0; t.alu = 64'hB; t.wen = 1'b1; t.rd = 5'd4; t.pc = 32'h104;
      cycle(t);
      chk("stall_allowin", {63'd0, allowin}, 64'd0);
      chk("stall_hold_pc", {32'd0, pc_o}, 64'h100);
    end
    chk("stall_no_commit", 64'(commits), 64'd0);
    t.allowout = 1'b1;
    cycle(t);
    chk("stall_release_pc", {32'd0, pc_o}, 64'h104);
    t = idle; t.allowout = 1'b1;
    cycle(t);
    chk("stall_commits", 64'(commits), 64'd2);

    // Reset in the middle of a stall drops the held instruction.
    t = idle; t.valid = 1'b1; t.allowout = 1'b1; t.wen = 1'b1; t.rd = 5'd7; t.cwen = 1'b1; t.fencei = 1'b1;
    cycle(t);
    t.valid = 1'b0; t.allowout = 1'b0;
    cycle(t);
    commits = 0;
    drive(t);
    do_reset();
    t = idle; t.allowout = 1'b1;
    cycle(t);
    chk("rst_drop_commits", 64'(commits), 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(rand_in());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
